// File: rtl/rd_pkg.sv
// Shared state encoding and word/count widths for the RD event-transfer path.
package rd_pkg;

  localparam int RD_WORD_BITS   = 13;
  localparam int RD_EVENT_WORDS = 2048;
  localparam int RD_COUNT_BITS  = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFR,
    ST_DONE,
    ST_ABORT
  } rd_state_e;

endpackage

// File: rtl/rd_edge_detect.sv
// Rise/fall detector for an already-synchronized level, built on a registered previous sample.
module rd_edge_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_prev;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  // The previous sample resets high: a level still high from before reset never reads as a new rise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_prev <= 1'b1;
    else          r_prev <= i_level;
  end

  assign o_rise =  i_level & ~r_prev;
  assign o_fall = ~i_level &  r_prev;

endmodule

// File: rtl/rd_xfr_scheduler.sv
// Allocates event buffers on trigger, supervises the RD serial transfer and reports completion.
// Optional watchdog/ABORT path is built only when RD_XFR_TIMEOUT_EN is defined.
module rd_xfr_scheduler
  import rd_pkg::*;
#(
  parameter int NBUF              = 4,
  parameter int BUF_ID_BITS       = 2,
  parameter int EXPECTED_WORDS    = RD_EVENT_WORDS,
  parameter int TRIG_PULSE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES    = 200000
) (
  input  logic                     AXI_CLK,
  input  logic                     AXI_RSTN,
  input  logic                     TRIGGER,
  input  logic                     XFR_ACTIVE,
  input  logic                     WORD_STROBE,
  input  logic                     BUF_RELEASE,
  input  logic [BUF_ID_BITS-1:0]   BUF_RELEASE_ID,
  output logic                     RD_TRIG_OUT,
  output logic [BUF_ID_BITS-1:0]   WR_BUF,
  output logic [NBUF-1:0]          BUF_FULL,
  output logic                     DONE,
  output logic [BUF_ID_BITS-1:0]   DONE_BUF,
  output logic [RD_COUNT_BITS-1:0] WORD_COUNT,
  output logic                     ERR_SHORT,
  output logic                     ERR_TIMEOUT,
  output logic [15:0]              DROP_COUNT
);

  localparam int                       PULSE_W       = (TRIG_PULSE_CYCLES > 1) ? $clog2(TRIG_PULSE_CYCLES) : 1;
  localparam logic [PULSE_W-1:0]       LP_PULSE_LOAD = PULSE_W'(TRIG_PULSE_CYCLES - 1);
  localparam logic [RD_COUNT_BITS-1:0] LP_EXPECTED   = RD_COUNT_BITS'(EXPECTED_WORDS);

  rd_state_e                r_state;
  logic                     r_rd_trig;
  logic [PULSE_W-1:0]       r_pulse_cnt;
  logic [BUF_ID_BITS-1:0]   r_wr_buf;
  logic [NBUF-1:0]          r_full;
  logic                     r_done;
  logic [BUF_ID_BITS-1:0]   r_done_buf;
  logic [RD_COUNT_BITS-1:0] r_word_cnt;
  logic [RD_COUNT_BITS-1:0] r_word_count;
  logic                     r_err_short;
  logic [15:0]              r_drop_cnt;

  logic                     w_rise;
  logic                     w_fall;
  logic [NBUF-1:0]          w_rel_mask;
  logic [NBUF-1:0]          w_full_rel;
  logic                     w_accept;
  logic                     w_drop;
  logic                     w_xfr_end;
  logic                     w_timeout;
  logic [RD_COUNT_BITS-1:0] w_word_next;

  rd_edge_detect u_xfr_edge (
    .i_clk   (AXI_CLK),
    .i_rst_n (AXI_RSTN),
    .i_level (XFR_ACTIVE),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // Release is applied before the free check, so releasing WR_BUF lets a same-cycle trigger in.
  assign w_rel_mask  = BUF_RELEASE ? (NBUF'(1) << BUF_RELEASE_ID) : '0;
  assign w_full_rel  = r_full & ~w_rel_mask;
  assign w_accept    = (r_state == ST_IDLE) && TRIGGER && !w_full_rel[r_wr_buf];
  assign w_drop      = TRIGGER && !w_accept;
  assign w_xfr_end   = (r_state == ST_XFR) && w_fall;
  assign w_word_next = (WORD_STROBE && (r_word_cnt != '1)) ? r_word_cnt + 1'b1 : r_word_cnt;

`ifdef RD_XFR_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_err_timeout;
  logic            w_wd_active;

  assign w_wd_active = (r_state == ST_REQ) || (r_state == ST_XFR);
  // A transfer ending on the limit cycle completes normally rather than aborting.
  assign w_timeout   = w_wd_active && !w_xfr_end && (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge AXI_CLK or negedge AXI_RSTN) begin
    if (!AXI_RSTN) begin
      r_wd_cnt      <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_accept)         r_wd_cnt <= '0;
      else if (w_wd_active) r_wd_cnt <= r_wd_cnt + 1'b1;
      if (w_timeout)        r_err_timeout <= 1'b1;
    end
  end

  assign ERR_TIMEOUT = r_err_timeout;
`else
  assign w_timeout   = 1'b0;
  assign ERR_TIMEOUT = 1'b0;
`endif

  always_ff @(posedge AXI_CLK or negedge AXI_RSTN) begin
    if (!AXI_RSTN) begin
      r_state      <= ST_IDLE;
      r_rd_trig    <= 1'b0;
      r_pulse_cnt  <= '0;
      r_wr_buf     <= '0;
      r_full       <= '0;
      r_done       <= 1'b0;
      r_done_buf   <= '0;
      r_word_cnt   <= '0;
      r_word_count <= '0;
      r_err_short  <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      r_full <= w_full_rel;

      if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 1'b1;

      if (w_accept) begin
        r_rd_trig   <= 1'b1;
        r_pulse_cnt <= LP_PULSE_LOAD;
      end else if (r_pulse_cnt != '0) begin
        r_pulse_cnt <= r_pulse_cnt - 1'b1;
      end else begin
        r_rd_trig   <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state    <= ST_REQ;
            r_word_cnt <= '0;
          end
        end
        ST_REQ: begin
          if (w_timeout)   r_state <= ST_ABORT;
          else if (w_rise) r_state <= ST_XFR;
        end
        ST_XFR: begin
          r_word_cnt <= w_word_next;
          // Completion results are registered on the fall itself so DONE and its data appear together.
          if (w_fall) begin
            r_state      <= ST_DONE;
            r_done       <= 1'b1;
            r_done_buf   <= r_wr_buf;
            r_word_count <= w_word_next;
            r_err_short  <= (w_word_next != LP_EXPECTED);
            r_full       <= w_full_rel | (NBUF'(1) << r_wr_buf);
            r_wr_buf     <= r_wr_buf + 1'b1;
          end else if (w_timeout) begin
            r_state      <= ST_ABORT;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
`ifdef RD_XFR_TIMEOUT_EN
        ST_ABORT: if (!XFR_ACTIVE) r_state <= ST_IDLE;
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign RD_TRIG_OUT = r_rd_trig;
  assign WR_BUF      = r_wr_buf;
  assign BUF_FULL    = r_full;
  assign DONE        = r_done;
  assign DONE_BUF    = r_done_buf;
  assign WORD_COUNT  = r_word_count;
  assign ERR_SHORT   = r_err_short;
  assign DROP_COUNT  = r_drop_cnt;

endmodule
